// File: rtl/lenet_l1_pkg.sv
// Shared types and defaults for the layer-1 front end (raster feeder and line buffer).
package lenet_l1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rf_state_t;

    localparam int PIX_W        = 2;
    localparam int IMG_ROWS_DEF = 32;
    localparam int IMG_COLS_DEF = 32;
    localparam int PAD_W        = 1;

endpackage

// File: rtl/rf_skid_buf.sv
// One-entry holding register for the pixel that was on the output when the stream stalled.
module rf_skid_buf #(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk_sys,
    input  logic                  rst_b,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] dout
);

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/img_raster_feeder.sv
// Streams one image from a 1-cycle-latency RAM in raster order into the layer-1 line buffer.
// Defining RF_ZERO_PAD_EN wraps the frame in a 1-pixel zero border generated without RAM reads.
//
// state | meaning
// IDLE  | waiting for rf_start_i
// FETCH | issuing reads (or border slots) in raster order
// DRAIN | all slots issued, waiting for the eof pixel to be accepted
// DONE  | one-cycle rf_done_o pulse
module img_raster_feeder
    import lenet_l1_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W,
    parameter int IMG_ROWS   = IMG_ROWS_DEF,
    parameter int IMG_COLS   = IMG_COLS_DEF,
    parameter int ADDR_WIDTH = $clog2(IMG_ROWS*IMG_COLS)
) (
    input  logic                  rf_clk,
    input  logic                  rf_rst_b,
    input  logic                  rf_start_i,
    input  logic                  rf_stall_i,
    output logic                  rf_mem_rd_o,
    output logic [ADDR_WIDTH-1:0] rf_mem_addr_o,
    input  logic [DATA_WIDTH-1:0] rf_mem_data_i,
    output logic [DATA_WIDTH-1:0] rf_out_o,
    output logic                  rf_valid_o,
    output logic                  rf_sof_o,
    output logic                  rf_eol_o,
    output logic                  rf_eof_o,
    output logic                  rf_busy_o,
    output logic                  rf_done_o
);

`ifdef RF_ZERO_PAD_EN
    localparam int PAD = PAD_W;
`else
    localparam int PAD = 0;
`endif
    localparam int OUT_R = IMG_ROWS + 2*PAD;
    localparam int OUT_C = IMG_COLS + 2*PAD;
    localparam int N_PIX = IMG_ROWS*IMG_COLS;
    localparam int RW    = $clog2(OUT_R + 1);
    localparam int CW    = $clog2(OUT_C + 1);

    rf_state_t             state;
    logic                  busy_q, done_q;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  pend_v, pend_pad;
    logic                  skid_full;
    logic [DATA_WIDTH-1:0] skid_data, live_d, pix_d;
    logic [RW-1:0]         o_row;
    logic [CW-1:0]         o_col;
    logic                  start_frame, issue, last_issue, slot_pad;
    logic                  pix_v, accept, o_last_row, o_last_col;

    assign start_frame = (state == IDLE) && rf_start_i;
    assign issue       = (state == FETCH) && !rf_stall_i && !skid_full;

`ifdef RF_ZERO_PAD_EN
    logic [RW-1:0] i_row;
    logic [CW-1:0] i_col;

    assign slot_pad   = (i_row == '0) || (i_row == RW'(OUT_R-1)) ||
                        (i_col == '0) || (i_col == CW'(OUT_C-1));
    assign last_issue = (i_row == RW'(OUT_R-1)) && (i_col == CW'(OUT_C-1));

    always_ff @(posedge rf_clk or negedge rf_rst_b) begin
        if (!rf_rst_b) begin
            i_row <= '0;
            i_col <= '0;
        end else if (start_frame) begin
            i_row <= '0;
            i_col <= '0;
        end else if (issue && !last_issue) begin
            if (i_col == CW'(OUT_C-1)) begin
                i_col <= '0;
                i_row <= i_row + 1'b1;
            end else begin
                i_col <= i_col + 1'b1;
            end
        end
    end
`else
    assign slot_pad   = 1'b0;
    assign last_issue = (addr == ADDR_WIDTH'(N_PIX-1));
`endif

    assign rf_mem_rd_o   = issue && !slot_pad;
    assign rf_mem_addr_o = addr;

    // Address saturates at the last pixel so trailing border slots never wrap it.
    always_ff @(posedge rf_clk or negedge rf_rst_b) begin
        if (!rf_rst_b) begin
            addr <= '0;
        end else if (start_frame) begin
            addr <= '0;
        end else if (rf_mem_rd_o && (addr != ADDR_WIDTH'(N_PIX-1))) begin
            addr <= addr + 1'b1;
        end
    end

    always_ff @(posedge rf_clk or negedge rf_rst_b) begin
        if (!rf_rst_b) begin
            pend_v   <= 1'b0;
            pend_pad <= 1'b0;
        end else begin
            pend_v   <= issue;
            pend_pad <= slot_pad;
        end
    end

    // The slot issued last cycle is presented straight from the RAM bus; a stalled one parks in the skid.
    assign live_d = pend_pad ? '0 : rf_mem_data_i;
    assign pix_v  = skid_full || pend_v;
    assign pix_d  = skid_full ? skid_data : (pend_v ? live_d : '0);
    assign accept = pix_v && !rf_stall_i;

    rf_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk_sys (rf_clk),
        .rst_b   (rf_rst_b),
        .load    (pend_v && !skid_full && rf_stall_i),
        .clear   (skid_full && !rf_stall_i),
        .din     (live_d),
        .full    (skid_full),
        .dout    (skid_data)
    );

    assign o_last_row = (o_row == RW'(OUT_R-1));
    assign o_last_col = (o_col == CW'(OUT_C-1));

    always_ff @(posedge rf_clk or negedge rf_rst_b) begin
        if (!rf_rst_b) begin
            o_row <= '0;
            o_col <= '0;
        end else if (start_frame) begin
            o_row <= '0;
            o_col <= '0;
        end else if (accept) begin
            if (o_last_col) begin
                o_col <= '0;
                o_row <= o_last_row ? '0 : o_row + 1'b1;
            end else begin
                o_col <= o_col + 1'b1;
            end
        end
    end

    always_ff @(posedge rf_clk or negedge rf_rst_b) begin
        if (!rf_rst_b) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rf_start_i) begin
                    state  <= FETCH;
                    busy_q <= 1'b1;
                end
                FETCH: if (issue && last_issue) state <= DRAIN;
                DRAIN: if (accept && o_last_row && o_last_col) begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rf_out_o   = pix_d;
    assign rf_valid_o = pix_v;
    assign rf_sof_o   = pix_v && (o_row == '0) && (o_col == '0);
    assign rf_eol_o   = pix_v && o_last_col;
    assign rf_eof_o   = pix_v && o_last_col && o_last_row;
    assign rf_busy_o  = busy_q;
    assign rf_done_o  = done_q;

endmodule

// File: tb/tb_img_raster_feeder.sv
// Directed bench for img_raster_feeder on a 4x4 image; also covers the padded 6x6 frame when RF_ZERO_PAD_EN is set.
module tb_img_raster_feeder;

    localparam int DW = 2;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int AW = 4;
`ifdef RF_ZERO_PAD_EN
    localparam int PR = R + 2;
    localparam int PC = C + 2;
`else
    localparam int PR = R;
    localparam int PC = C;
`endif
    localparam int NP = PR*PC;

    logic          rf_clk = 1'b0;
    logic          rf_rst_b;
    logic          rf_start_i;
    logic          rf_stall_i;
    logic          rf_mem_rd_o;
    logic [AW-1:0] rf_mem_addr_o;
    logic [DW-1:0] rf_mem_data_i;
    logic [DW-1:0] rf_out_o;
    logic          rf_valid_o, rf_sof_o, rf_eol_o, rf_eof_o, rf_busy_o, rf_done_o;

    img_raster_feeder #(.DATA_WIDTH(DW), .IMG_ROWS(R), .IMG_COLS(C), .ADDR_WIDTH(AW)) dut (
        .rf_clk        (rf_clk),
        .rf_rst_b      (rf_rst_b),
        .rf_start_i    (rf_start_i),
        .rf_stall_i    (rf_stall_i),
        .rf_mem_rd_o   (rf_mem_rd_o),
        .rf_mem_addr_o (rf_mem_addr_o),
        .rf_mem_data_i (rf_mem_data_i),
        .rf_out_o      (rf_out_o),
        .rf_valid_o    (rf_valid_o),
        .rf_sof_o      (rf_sof_o),
        .rf_eol_o      (rf_eol_o),
        .rf_eof_o      (rf_eof_o),
        .rf_busy_o     (rf_busy_o),
        .rf_done_o     (rf_done_o)
    );

    always #5 rf_clk = ~rf_clk;

    logic [DW-1:0] mem [0:15];
    logic [DW-1:0] ram_q = '0;
    always @(posedge rf_clk) if (rf_mem_rd_o) ram_q <= mem[rf_mem_addr_o];
    assign rf_mem_data_i = ram_q;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] got [0:63];
    int n_pix, done_cnt, done_i, first_v_i, max_addr, hold_bad, stalled_cnt, busy_cnt;
    logic hit_rst;

    // {data, sof, eol, eof} of the k-th accepted pixel
    function automatic logic [4:0] exp_pix(input int k);
        int c;
        logic [1:0] d;
        c = k % PC;
`ifdef RF_ZERO_PAD_EN
        begin
            int r;
            r = k / PC;
            d = (r == 0 || r == PR-1 || c == 0 || c == PC-1) ? 2'd0 : 2'd3;
        end
`else
        d = 2'(k % 4);
`endif
        return {d, (k == 0), (c == PC-1), (k == NP-1)};
    endfunction

    // mode 0: no stall, 1: stall over cycles [s_from, s_to], 2: stall on even cycles
    task automatic collect(input int mode, input int s_from, input int s_to,
                           input int restart_i, input int rst_i);
        logic [4:0] snap, cur;
        logic held;
        int post;
        for (int k = 0; k < 64; k++) got[k] = 'x;
        n_pix = 0; done_cnt = 0; done_i = 0; first_v_i = 0; max_addr = 0;
        hold_bad = 0; stalled_cnt = 0; busy_cnt = 0; hit_rst = 1'b0;
        held = 1'b0; post = 0; snap = '0;
        rf_start_i = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge rf_clk); #1;
            rf_start_i = (i == restart_i);
            case (mode)
                1:       rf_stall_i = (i >= s_from) && (i <= s_to);
                2:       rf_stall_i = (i % 2 == 0);
                default: rf_stall_i = 1'b0;
            endcase
            if (i == rst_i) begin
                rf_stall_i = 1'b0;
                rf_rst_b   = 1'b0;
                hit_rst    = 1'b1;
                #1;
                break;
            end
            #1;
            cur = {rf_out_o, rf_sof_o, rf_eol_o, rf_eof_o};
            if (held && (!rf_valid_o || cur != snap)) hold_bad++;
            held = rf_valid_o && rf_stall_i;
            snap = cur;
            if (rf_valid_o && rf_stall_i) stalled_cnt++;
            if (rf_valid_o && first_v_i == 0) first_v_i = i;
            if (rf_valid_o && !rf_stall_i) begin
                if (n_pix < 64) got[n_pix] = cur;
                n_pix++;
            end
            if (rf_mem_rd_o && int'(rf_mem_addr_o) > max_addr) max_addr = int'(rf_mem_addr_o);
            if (rf_busy_o) busy_cnt++;
            if (rf_done_o) begin
                done_cnt++;
                if (done_i == 0) done_i = i;
            end
            if (done_cnt > 0) begin
                post++;
                if (post > 3) break;
            end
        end
        rf_start_i = 1'b0;
        rf_stall_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] outs;
        rf_rst_b = 1'b0; rf_start_i = 1'b0; rf_stall_i = 1'b0;
        repeat (2) @(posedge rf_clk);
        #1;
        outs = {rf_mem_rd_o, rf_mem_addr_o, rf_out_o, rf_valid_o, rf_sof_o, rf_eol_o, rf_eof_o, rf_busy_o, rf_done_o};
        n_checks++;
        if (outs !== 13'd0) begin n_fail++; $display("FAIL reset_outputs got=%b exp=0", outs); end
        rf_rst_b = 1'b1;
        repeat (3) @(posedge rf_clk);
        #1;
        outs = {rf_mem_rd_o, rf_mem_addr_o, rf_out_o, rf_valid_o, rf_sof_o, rf_eol_o, rf_eof_o, rf_busy_o, rf_done_o};
        n_checks++;
        if (outs !== 13'd0) begin n_fail++; $display("FAIL idle_quiet got=%b exp=0", outs); end
    endtask

    task automatic test_basic();
        collect(0, 0, 0, 0, 0);
        for (int k = 0; k < NP; k++) begin
            n_checks++;
            if (got[k] !== exp_pix(k)) begin n_fail++; $display("FAIL basic_pix%0d got=%b exp=%b", k, got[k], exp_pix(k)); end
        end
        n_checks++;
        if (n_pix !== NP) begin n_fail++; $display("FAIL basic_count got=%0d exp=%0d", n_pix, NP); end
        n_checks++;
        if (first_v_i !== 2) begin n_fail++; $display("FAIL basic_first_valid got=%0d exp=2", first_v_i); end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
        n_checks++;
        if (done_i !== NP+2) begin n_fail++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_i, NP+2); end
        n_checks++;
        if (busy_cnt !== NP+1) begin n_fail++; $display("FAIL basic_busy got=%0d exp=%0d", busy_cnt, NP+1); end
        n_checks++;
        if (max_addr > 15) begin n_fail++; $display("FAIL basic_max_addr got=%0d exp<=15", max_addr); end
    endtask

    task automatic test_stall();
        // pixel 5 first appears in cycle 6; hold the stream for 3 cycles there
        collect(1, 6, 8, 0, 0);
        for (int k = 0; k < NP; k++) begin
            n_checks++;
            if (got[k] !== exp_pix(k)) begin n_fail++; $display("FAIL stall_pix%0d got=%b exp=%b", k, got[k], exp_pix(k)); end
        end
        n_checks++;
        if (n_pix !== NP) begin n_fail++; $display("FAIL stall_count got=%0d exp=%0d", n_pix, NP); end
        n_checks++;
        if (stalled_cnt !== 3) begin n_fail++; $display("FAIL stall_frozen_cycles got=%0d exp=3", stalled_cnt); end
        n_checks++;
        if (hold_bad !== 0) begin n_fail++; $display("FAIL stall_hold got=%0d exp=0", hold_bad); end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL stall_done_cnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_restart_busy();
        collect(0, 0, 0, 9, 0);
        for (int k = 0; k < NP; k++) begin
            n_checks++;
            if (got[k] !== exp_pix(k)) begin n_fail++; $display("FAIL restart_pix%0d got=%b exp=%b", k, got[k], exp_pix(k)); end
        end
        n_checks++;
        if (n_pix !== NP) begin n_fail++; $display("FAIL restart_count got=%0d exp=%0d", n_pix, NP); end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL restart_done_cnt got=%0d exp=1", done_cnt); end
        n_checks++;
        if (done_i !== NP+2) begin n_fail++; $display("FAIL restart_done_cycle got=%0d exp=%0d", done_i, NP+2); end
    endtask

    task automatic test_start_in_done();
        collect(0, 0, 0, NP+2, 0);
        n_checks++;
        if (n_pix !== NP) begin n_fail++; $display("FAIL done_start_count got=%0d exp=%0d", n_pix, NP); end
        n_checks++;
        if (busy_cnt !== NP+1) begin n_fail++; $display("FAIL done_start_busy got=%0d exp=%0d", busy_cnt, NP+1); end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL done_start_done_cnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [12:0] outs;
        // pixel 10 first appears in cycle 11
        collect(0, 0, 0, 0, 11);
        outs = {rf_mem_rd_o, rf_mem_addr_o, rf_out_o, rf_valid_o, rf_sof_o, rf_eol_o, rf_eof_o, rf_busy_o, rf_done_o};
        n_checks++;
        if (hit_rst !== 1'b1) begin n_fail++; $display("FAIL rstmid_reached got=%b exp=1", hit_rst); end
        n_checks++;
        if (n_pix !== 9) begin n_fail++; $display("FAIL rstmid_partial got=%0d exp=9", n_pix); end
        n_checks++;
        if (outs !== 13'd0) begin n_fail++; $display("FAIL rstmid_outputs got=%b exp=0", outs); end
        @(posedge rf_clk); #1;
        rf_rst_b = 1'b1;
        @(posedge rf_clk); #1;
        n_checks++;
        if (rf_done_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done got=%b exp=0", rf_done_o); end
        collect(0, 0, 0, 0, 0);
        for (int k = 0; k < NP; k++) begin
            n_checks++;
            if (got[k] !== exp_pix(k)) begin n_fail++; $display("FAIL rstmid_pix%0d got=%b exp=%b", k, got[k], exp_pix(k)); end
        end
        n_checks++;
        if (n_pix !== NP) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=%0d", n_pix, NP); end
        n_checks++;
        if (done_i !== NP+2) begin n_fail++; $display("FAIL rstmid_done_cycle got=%0d exp=%0d", done_i, NP+2); end
    endtask

    task automatic test_toggle_stall();
        collect(2, 0, 0, 0, 0);
        for (int k = 0; k < NP; k++) begin
            n_checks++;
            if (got[k] !== exp_pix(k)) begin n_fail++; $display("FAIL toggle_pix%0d got=%b exp=%b", k, got[k], exp_pix(k)); end
        end
        n_checks++;
        if (n_pix !== NP) begin n_fail++; $display("FAIL toggle_count got=%0d exp=%0d", n_pix, NP); end
        n_checks++;
        if (max_addr > 15) begin n_fail++; $display("FAIL toggle_max_addr got=%0d exp<=15", max_addr); end
        n_checks++;
        if (hold_bad !== 0) begin n_fail++; $display("FAIL toggle_hold got=%0d exp=0", hold_bad); end
        n_checks++;
        if (stalled_cnt == 0) begin n_fail++; $display("FAIL toggle_stalled got=0 exp>0"); end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL toggle_done_cnt got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) begin
`ifdef RF_ZERO_PAD_EN
            mem[a] = 2'd3;
`else
            mem[a] = 2'(a % 4);
`endif
        end
        rf_rst_b = 1'b0;
        rf_start_i = 1'b0;
        rf_stall_i = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_restart_busy();
        test_start_in_done();
        test_reset_mid();
        test_toggle_stall();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
